csr_trap_ctrl: RTL and testbench

CSR_TRAP_CTRL -- requirements
Module: csr_trap_ctrl

---
 rtl/csr_trap_ctrl_pkg.sv | 33 +++
 rtl/csr_trap_ctrl_if.sv | 34 +++
 rtl/csr_trap_ctrl_irq_prio.sv | 44 ++++
 rtl/csr_trap_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_csr_trap_ctrl.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/csr_trap_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// csr_trap_ctrl_pkg
// Shared definitions for the machine-mode trap/mret sequencer:
//   - FSM state encoding
//   - default CSR addresses (mstatus, mepc, mcause)
//   - machine interrupt cause codes (MSI=3, MTI=7, MEI=11)
//   - mstatus bit positions used by the sequencer
// -----------------------------------------------------------------------------
package csr_trap_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_MEPC,
        S_W_MCAUSE,
        S_W_MSTATUS,
        S_REDIRECT
    } trap_state_t;

    localparam logic [11:0] CSR_ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_ADDR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_ADDR_MCAUSE  = 12'h342;

    localparam logic [4:0] IRQ_MSI = 5'd3;
    localparam logic [4:0] IRQ_MTI = 5'd7;
    localparam logic [4:0] IRQ_MEI = 5'd11;

    localparam int unsigned MSTATUS_MIE  = 3;
    localparam int unsigned MSTATUS_MPIE = 7;

    // mtvec[1:0] encoding that selects vectored interrupt dispatch
    localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

endpackage

// File: rtl/csr_trap_ctrl_if.sv
// -----------------------------------------------------------------------------
// csr_trap_ctrl_if
// CSR write bus between the trap sequencer (master) and the CSR file (slave).
//   csr_en_o     write strobe, held until acknowledged
//   csr_addr_o   12-bit CSR address
//   csr_set_o    bits to set
//   csr_clear_o  bits to clear
//   csr_ack_i    CSR file accepted the current access
// -----------------------------------------------------------------------------
interface csr_trap_ctrl_if;

    logic        csr_en_o;
    logic [11:0] csr_addr_o;
    logic [31:0] csr_set_o;
    logic [31:0] csr_clear_o;
    logic        csr_ack_i;

    modport master (
        output csr_en_o,
        output csr_addr_o,
        output csr_set_o,
        output csr_clear_o,
        input  csr_ack_i
    );

    modport slave (
        input  csr_en_o,
        input  csr_addr_o,
        input  csr_set_o,
        input  csr_clear_o,
        output csr_ack_i
    );

endinterface

// File: rtl/csr_trap_ctrl_irq_prio.sv
// -----------------------------------------------------------------------------
// csr_irq_prio
// Combinational machine-interrupt priority encoder.
//   global_ie_i  mstatus.MIE
//   mie_i/mip_i  interrupt enable / pending vectors
//   pending_o    an enabled interrupt is pending and globally enabled
//   code_o       winning cause code, priority MEI(11) > MSI(3) > MTI(7)
// -----------------------------------------------------------------------------
module csr_irq_prio
    import csr_trap_ctrl_pkg::*;
(
    input  logic        global_ie_i,
    input  logic [31:0] mie_i,
    input  logic [31:0] mip_i,
    output logic        pending_o,
    output logic [4:0]  code_o
);

    logic [31:0] active;
    logic        unused_active;

    assign active = mie_i & mip_i;

    // Only the three standard machine interrupt lines are arbitrated here
    assign unused_active = ^{active[31:12], active[10:8], active[6:4], active[2:0]};

    always_comb begin
        pending_o = 1'b0;
        code_o    = '0;
        if (global_ie_i) begin
            if (active[IRQ_MEI]) begin
                pending_o = 1'b1;
                code_o    = IRQ_MEI;
            end else if (active[IRQ_MSI]) begin
                pending_o = 1'b1;
                code_o    = IRQ_MSI;
            end else if (active[IRQ_MTI]) begin
                pending_o = 1'b1;
                code_o    = IRQ_MTI;
            end
        end
    end

endmodule

// File: rtl/csr_trap_ctrl.sv
// -----------------------------------------------------------------------------
// csr_trap_ctrl
// Machine-mode trap entry / mret sequencer. Accepts one event in IDLE
// (exception > interrupt > mret), writes mepc, mcause and mstatus through the
// CSR bus (mret writes only mstatus), then issues a one-cycle PC redirect.
//   clk_i, rst_i       clock, asynchronous active-high reset
//   exc_*              synchronous exception request, cause, faulting PC
//   mret_i             mret retiring
//   irq_pc_i           resume PC for interrupts
//   mstatus_i          MIE (bit3) / MPIE (bit7) source
//   mie_i, mip_i       interrupt enable / pending
//   mtvec_i            trap vector base [31:2], mode [1:0]
//   mepc_i             current mepc, used as mret target
//   csr_bus            CSR write bus (master side)
//   stall_o            hold pipeline while a sequence is in flight
//   redirect_valid_o   one-cycle redirect plus flush
//   redirect_pc_o      redirect target
// -----------------------------------------------------------------------------
module csr_trap_ctrl
    import csr_trap_ctrl_pkg::*;
#(
    parameter logic [11:0] ADDR_MSTATUS = CSR_ADDR_MSTATUS,
    parameter logic [11:0] ADDR_MEPC    = CSR_ADDR_MEPC,
    parameter logic [11:0] ADDR_MCAUSE  = CSR_ADDR_MCAUSE
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   exc_valid_i,
    input  logic [4:0]             exc_cause_i,
    input  logic [31:0]            exc_pc_i,
    input  logic                   mret_i,
    input  logic [31:0]            irq_pc_i,
    input  logic [31:0]            mstatus_i,
    input  logic [31:0]            mie_i,
    input  logic [31:0]            mip_i,
    input  logic [31:0]            mtvec_i,
    input  logic [31:0]            mepc_i,
    csr_trap_ctrl_if.master        csr_bus,
    output logic                   stall_o,
    output logic                   redirect_valid_o,
    output logic [31:0]            redirect_pc_o
);

    trap_state_t state_q, state_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] cause_q, cause_d;
    logic        mie_q, mie_d;
    logic        mpie_q, mpie_d;
    logic        mret_q, mret_d;
    logic        accept;

    logic        irq_pending;
    logic [4:0]  irq_code;
    logic [31:0] vec_base;
    logic        unused_bits;

    logic        csr_en;
    logic [11:0] csr_addr;
    logic [31:0] csr_set;
    logic [31:0] csr_clear;

    assign unused_bits = ^{mstatus_i[31:8], mstatus_i[6:4], mstatus_i[2:0], mepc_i[1:0]};

    csr_irq_prio u_irq_prio (
        .global_ie_i (mstatus_i[MSTATUS_MIE]),
        .mie_i       (mie_i),
        .mip_i       (mip_i),
        .pending_o   (irq_pending),
        .code_o      (irq_code)
    );

    always_comb begin
        state_d = state_q;
        epc_d   = epc_q;
        cause_d = cause_q;
        mie_d   = mie_q;
        mpie_d  = mpie_q;
        mret_d  = mret_q;
        accept  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (exc_valid_i) begin
                    accept  = 1'b1;
                    epc_d   = exc_pc_i;
                    cause_d = {1'b0, 26'b0, exc_cause_i};
                    mret_d  = 1'b0;
                    state_d = S_W_MEPC;
                end else if (irq_pending) begin
                    accept  = 1'b1;
                    epc_d   = irq_pc_i;
                    cause_d = {1'b1, 26'b0, irq_code};
                    mret_d  = 1'b0;
                    state_d = S_W_MEPC;
                end else if (mret_i) begin
                    accept  = 1'b1;
                    mret_d  = 1'b1;
                    state_d = S_W_MSTATUS;
                end
                if (accept) begin
                    mie_d  = mstatus_i[MSTATUS_MIE];
                    mpie_d = mstatus_i[MSTATUS_MPIE];
                end
            end
            S_W_MEPC:    if (csr_bus.csr_ack_i) state_d = S_W_MCAUSE;
            S_W_MCAUSE:  if (csr_bus.csr_ack_i) state_d = S_W_MSTATUS;
            S_W_MSTATUS: if (csr_bus.csr_ack_i) state_d = S_REDIRECT;
            S_REDIRECT:  state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            epc_q   <= '0;
            cause_q <= '0;
            mie_q   <= 1'b0;
            mpie_q  <= 1'b0;
            mret_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
            mie_q   <= mie_d;
            mpie_q  <= mpie_d;
            mret_q  <= mret_d;
        end
    end

    assign vec_base = {mtvec_i[31:2], 2'b00};

    // Outputs decode only flops, except the redirect target, which must use
    // mtvec/mepc as seen in the REDIRECT cycle itself.
    always_comb begin
        csr_en           = 1'b0;
        csr_addr         = '0;
        csr_set          = '0;
        csr_clear        = '0;
        redirect_valid_o = 1'b0;
        redirect_pc_o    = '0;
        unique case (state_q)
            S_W_MEPC: begin
                csr_en    = 1'b1;
                csr_addr  = ADDR_MEPC;
                csr_set   = epc_q;
                csr_clear = ~epc_q;
            end
            S_W_MCAUSE: begin
                csr_en    = 1'b1;
                csr_addr  = ADDR_MCAUSE;
                csr_set   = cause_q;
                csr_clear = ~cause_q;
            end
            S_W_MSTATUS: begin
                csr_en   = 1'b1;
                csr_addr = ADDR_MSTATUS;
                if (mret_q) begin
                    csr_set[MSTATUS_MPIE] = 1'b1;
                    csr_set[MSTATUS_MIE]  = mpie_q;
                    csr_clear[MSTATUS_MIE] = ~mpie_q;
                end else begin
                    csr_set[MSTATUS_MPIE]   = mie_q;
                    csr_clear[MSTATUS_MPIE] = ~mie_q;
                    csr_clear[MSTATUS_MIE]  = 1'b1;
                end
            end
            S_REDIRECT: begin
                redirect_valid_o = 1'b1;
                if (mret_q)
                    redirect_pc_o = {mepc_i[31:2], 2'b00};
                else if (cause_q[31] && (mtvec_i[1:0] == MTVEC_MODE_VECTORED))
                    redirect_pc_o = vec_base + {25'b0, cause_q[4:0], 2'b00};
                else
                    redirect_pc_o = vec_base;
            end
            default: ;
        endcase
    end

    assign csr_bus.csr_en_o    = csr_en;
    assign csr_bus.csr_addr_o  = csr_addr;
    assign csr_bus.csr_set_o   = csr_set;
    assign csr_bus.csr_clear_o = csr_clear;

    // Gated by reset so an event presented during reset cannot raise stall
    assign stall_o = ~rst_i & (accept | (state_q != S_IDLE));

endmodule

// File: tb/tb_csr_trap_ctrl.sv
module tb_csr_trap_ctrl;

    typedef struct packed {
        logic        is_redirect;
        logic [11:0] addr;
        logic [31:0] a;   // set mask, or redirect pc
        logic [31:0] b;   // clear mask
    } txn_t;

    logic        clk;
    logic        rst;
    logic        exc_valid;
    logic [4:0]  exc_cause;
    logic [31:0] exc_pc;
    logic        mret;
    logic [31:0] irq_pc;
    logic [31:0] mstatus;
    logic [31:0] mie;
    logic [31:0] mip;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int checks   = 0;
    int failures = 0;
    txn_t exp_q[$];

    csr_trap_ctrl_if bus ();

    csr_trap_ctrl #(
        .ADDR_MSTATUS (12'h300),
        .ADDR_MEPC    (12'h341),
        .ADDR_MCAUSE  (12'h342)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .exc_valid_i      (exc_valid),
        .exc_cause_i      (exc_cause),
        .exc_pc_i         (exc_pc),
        .mret_i           (mret),
        .irq_pc_i         (irq_pc),
        .mstatus_i        (mstatus),
        .mie_i            (mie),
        .mip_i            (mip),
        .mtvec_i          (mtvec),
        .mepc_i           (mepc),
        .csr_bus          (bus.master),
        .stall_o          (stall),
        .redirect_valid_o (redirect_valid),
        .redirect_pc_o    (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    task automatic push_csr(input logic [11:0] addr, input logic [31:0] set, input logic [31:0] clr);
        exp_q.push_back('{is_redirect: 1'b0, addr: addr, a: set, b: clr});
    endtask

    task automatic push_redirect(input logic [31:0] pc);
        exp_q.push_back('{is_redirect: 1'b1, addr: 12'h000, a: pc, b: 32'h0});
    endtask

    // Monitor: every accepted CSR write and every redirect is one observed transaction
    initial begin
        txn_t exp;
        forever begin
            @(negedge clk);
            if (!rst && ((bus.csr_en_o && bus.csr_ack_i) || redirect_valid)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output actual=addr 0x%03h redirect %0b required=none",
                             bus.csr_addr_o, redirect_valid);
                end else begin
                    exp = exp_q.pop_front();
                    check("txn_kind", {31'b0, redirect_valid}, {31'b0, exp.is_redirect});
                    if (exp.is_redirect) begin
                        check("redirect_pc", redirect_pc, exp.a);
                    end else begin
                        check("csr_addr", {20'b0, bus.csr_addr_o}, {20'b0, exp.addr});
                        check("csr_set", bus.csr_set_o, exp.a);
                        check("csr_clear", bus.csr_clear_o, exp.b);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_events();
        exc_valid = 1'b0;
        mret      = 1'b0;
        mie       = 32'h0;
        mip       = 32'h0;
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_stall"}, {31'b0, stall}, 32'h0);
        check({name, "_csr_en"}, {31'b0, bus.csr_en_o}, 32'h0);
        check({name, "_addr"}, {20'b0, bus.csr_addr_o}, 32'h0);
        check({name, "_set"}, bus.csr_set_o, 32'h0);
        check({name, "_clear"}, bus.csr_clear_o, 32'h0);
        check({name, "_rvalid"}, {31'b0, redirect_valid}, 32'h0);
        check({name, "_rpc"}, redirect_pc, 32'h0);
    endtask

    // Event already applied at posedge+1; measures cycles from acceptance to redirect
    task automatic run_seq(input string name, input int exp_lat);
        int  n;
        bit  seen;
        seen = 1'b0;
        #1;
        check({name, "_stall_accept"}, {31'b0, stall}, 32'h1);
        for (n = 1; n <= 20; n++) begin
            tick();
            if (n == 1) clear_events();
            #1;
            if (redirect_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check({name, "_redirect_seen"}, {31'b0, seen}, 32'h1);
        check({name, "_latency"}, n, exp_lat);
        tick();
        check({name, "_idle_stall"}, {31'b0, stall}, 32'h0);
        check({name, "_idle_rvalid"}, {31'b0, redirect_valid}, 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        bus.csr_ack_i = 1'b1;
        exc_cause = 5'd0;
        exc_pc    = 32'h0;
        irq_pc    = 32'h0;
        mstatus   = 32'h0000_0008;
        mtvec     = 32'h8000_0001;
        mepc      = 32'h0;
        clear_events();
        exc_valid = 1'b1;   // must not leak through while reset is held
        tick();
        tick();
        check_all_zero("reset");
        exc_valid = 1'b0;
        rst = 1'b0;
        tick();

        // Exception, vectored mtvec ignored for exceptions
        mstatus = 32'h0000_0008; mtvec = 32'h8000_0001;
        exc_cause = 5'd2; exc_pc = 32'h0000_0100; exc_valid = 1'b1;
        push_csr(12'h341, 32'h0000_0100, 32'hFFFF_FEFF);
        push_csr(12'h342, 32'h0000_0002, 32'hFFFF_FFFD);
        push_csr(12'h300, 32'h0000_0080, 32'h0000_0008);
        push_redirect(32'h8000_0000);
        run_seq("exc", 4);

        // Machine timer interrupt, vectored
        irq_pc = 32'h0000_0400; mie = 32'h80; mip = 32'h80;
        push_csr(12'h341, 32'h0000_0400, 32'hFFFF_FBFF);
        push_csr(12'h342, 32'h8000_0007, 32'h7FFF_FFF8);
        push_csr(12'h300, 32'h0000_0080, 32'h0000_0008);
        push_redirect(32'h8000_001C);
        run_seq("mti", 4);

        // All three lines pending: MEI wins
        mtvec = 32'h2000_0001; irq_pc = 32'h0000_0500;
        mie = 32'h0000_0888; mip = 32'h0000_0888;
        push_csr(12'h341, 32'h0000_0500, 32'hFFFF_FAFF);
        push_csr(12'h342, 32'h8000_000B, 32'h7FFF_FFF4);
        push_csr(12'h300, 32'h0000_0080, 32'h0000_0008);
        push_redirect(32'h2000_002C);
        run_seq("mei_prio", 4);

        // MSI beats MTI
        mie = 32'h0000_0088; mip = 32'h0000_0088;
        push_csr(12'h341, 32'h0000_0500, 32'hFFFF_FAFF);
        push_csr(12'h342, 32'h8000_0003, 32'h7FFF_FFFC);
        push_csr(12'h300, 32'h0000_0080, 32'h0000_0008);
        push_redirect(32'h2000_000C);
        run_seq("msi_prio", 4);

        // Global MIE clear: pending MEI must be ignored
        mstatus = 32'h0000_0080; mie = 32'h800; mip = 32'h800;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("mie0_stall", {31'b0, stall}, 32'h0);
            check("mie0_csr_en", {31'b0, bus.csr_en_o}, 32'h0);
            tick();
        end
        clear_events();

        // Exception + MEI + mret together: exception path, mode-0 vector
        mstatus = 32'h0000_0008; mtvec = 32'h0000_1000;
        exc_cause = 5'd5; exc_pc = 32'h0000_0200; exc_valid = 1'b1;
        mie = 32'h800; mip = 32'h800; mret = 1'b1; irq_pc = 32'h0000_0600;
        push_csr(12'h341, 32'h0000_0200, 32'hFFFF_FDFF);
        push_csr(12'h342, 32'h0000_0005, 32'hFFFF_FFFA);
        push_csr(12'h300, 32'h0000_0080, 32'h0000_0008);
        push_redirect(32'h0000_1000);
        run_seq("collide", 4);

        // Exception with MIE=0: MPIE cleared, MIE cleared
        mstatus = 32'h0000_0000; mtvec = 32'h0000_1000;
        exc_cause = 5'd31; exc_pc = 32'hFFFF_FFFC; exc_valid = 1'b1;
        push_csr(12'h341, 32'hFFFF_FFFC, 32'h0000_0003);
        push_csr(12'h342, 32'h0000_001F, 32'hFFFF_FFE0);
        push_csr(12'h300, 32'h0000_0000, 32'h0000_0088);
        push_redirect(32'h0000_1000);
        run_seq("exc_mie0", 4);

        // mret, MPIE=1
        mstatus = 32'h0000_0080; mepc = 32'h0000_0204; mret = 1'b1;
        push_csr(12'h300, 32'h0000_0088, 32'h0000_0000);
        push_redirect(32'h0000_0204);
        run_seq("mret_mpie1", 2);

        // Ack withheld three cycles in W_MCAUSE, then reset in W_MSTATUS
        mstatus = 32'h0000_0008; mtvec = 32'h0000_0400;
        exc_cause = 5'd1; exc_pc = 32'h0000_0300; exc_valid = 1'b1;
        push_csr(12'h341, 32'h0000_0300, 32'hFFFF_FCFF);
        push_csr(12'h342, 32'h0000_0001, 32'hFFFF_FFFE);
        tick();
        clear_events();
        check("wait_mepc_addr", {20'b0, bus.csr_addr_o}, 32'h341);
        tick();
        bus.csr_ack_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("wait_en", {31'b0, bus.csr_en_o}, 32'h1);
            check("wait_addr", {20'b0, bus.csr_addr_o}, 32'h342);
            check("wait_set", bus.csr_set_o, 32'h0000_0001);
            check("wait_clear", bus.csr_clear_o, 32'hFFFF_FFFE);
            check("wait_stall", {31'b0, stall}, 32'h1);
            tick();
        end
        check("wait_no_advance", {20'b0, bus.csr_addr_o}, 32'h342);
        bus.csr_ack_i = 1'b1;
        tick();
        check("mstatus_reached", {20'b0, bus.csr_addr_o}, 32'h300);
        rst = 1'b1;
        #1;
        check_all_zero("midreset");
        tick();
        rst = 1'b0;
        tick();
        check("post_reset_stall", {31'b0, stall}, 32'h0);

        // mret with MPIE=0 after reset; mepc low bits forced to zero
        mstatus = 32'h0000_0008; mepc = 32'h0000_0307; mret = 1'b1;
        push_csr(12'h300, 32'h0000_0080, 32'h0000_0008);
        push_redirect(32'h0000_0304);
        run_seq("mret_mpie0", 2);

        tick();
        tick();
        check("scoreboard_drained", exp_q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
